// File: rtl/crc5_token_checker_pkg.sv
// Shared CRC5 token definitions for the token receive/transmit path.
// Holds field sizes, the receiver state encoding and the CRC5 function.
package crc5_pkg;

    localparam logic [4:0] CRC5_INIT  = 5'h1F;
    localparam int         TOKEN_BITS = 16;
    localparam int         DATA_BITS  = 11;
    localparam int         CRC_BITS   = TOKEN_BITS - DATA_BITS;

    typedef enum logic {
        IDLE,
        RECV
    } state_e;

    // Single parallel step of the 11-bit CRC5 generator seeded with CRC5_INIT
    function automatic logic [4:0] crc5_calc(input logic [DATA_BITS-1:0] d);
        logic [4:0] c;
        c[0] = ~(d[0] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10]);
        c[1] = ~(d[1] ^ d[4] ^ d[6] ^ d[7] ^ d[10]);
        c[2] = ~(d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10]);
        c[3] =   d[1] ^ d[3] ^ d[4] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        c[4] = ~(d[2] ^ d[4] ^ d[5] ^ d[8] ^ d[9] ^ d[10]);
        return c;
    endfunction

endpackage

// File: rtl/crc5_token_checker_if.sv
// Serial token input and decoded token results of the CRC5 checker.
// master = line-side driver, slave = the checker itself.
interface crc5_token_checker_if #(
    parameter int ERR_CNT_W = 8
);

    logic                 bit_en;
    logic                 bit_in;
    logic                 sop;
    logic                 busy;
    logic                 tok_valid;
    logic                 crc_err;
    logic                 abort;
    logic [6:0]           addr;
    logic [3:0]           endp;
    logic [4:0]           crc_rx;
    logic [4:0]           crc_calc;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output bit_en, bit_in, sop,
        input  busy, tok_valid, crc_err, abort,
        input  addr, endp, crc_rx, crc_calc, err_cnt
    );

    modport slave (
        input  bit_en, bit_in, sop,
        output busy, tok_valid, crc_err, abort,
        output addr, endp, crc_rx, crc_calc, err_cnt
    );

endinterface

// File: rtl/crc5_token_checker.sv
// Deserialises 16-bit LSB-first tokens, rechecks their CRC5 and
// reports good tokens, CRC errors and sop-aborted partial tokens.
module crc5_token_checker
    import crc5_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    crc5_token_checker_if.slave tok
);

    localparam int SR_W = TOKEN_BITS - 1;
    localparam logic [3:0] LAST_IDX = 4'(TOKEN_BITS - 1);

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [SR_W-1:0]      shift_q;
    logic                 tok_valid_q;
    logic                 crc_err_q;
    logic                 abort_q;
    logic [6:0]           addr_q;
    logic [3:0]           endp_q;
    logic [4:0]           crc_rx_q;
    logic [4:0]           crc_calc_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [TOKEN_BITS-1:0] word_d;
    logic [DATA_BITS-1:0]  data_d;
    logic [4:0]            crc_rx_d;
    logic [4:0]            crc_calc_d;
    logic                  last_d;

    // The 16th bit is never stored; it completes the word on the fly
    always_comb begin
        word_d     = {tok.bit_in, shift_q};
        data_d     = word_d[DATA_BITS-1:0];
        crc_rx_d   = word_d[TOKEN_BITS-1:DATA_BITS];
        crc_calc_d = crc5_calc(data_d);
        last_d     = (state_q == RECV) && (cnt_q == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tok_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            endp_q      <= '0;
            crc_rx_q    <= '0;
            crc_calc_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            tok_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            if (tok.bit_en) begin
                if (tok.sop) begin
                    // A sop always restarts, even over a would-be last bit
                    abort_q <= (state_q == RECV);
                    state_q <= RECV;
                    cnt_q   <= 4'd1;
                    shift_q <= {tok.bit_in, {(SR_W-1){1'b0}}};
                end else if (last_d) begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    addr_q     <= data_d[6:0];
                    endp_q     <= data_d[10:7];
                    crc_rx_q   <= crc_rx_d;
                    crc_calc_q <= crc_calc_d;
                    if (crc_rx_d == crc_calc_d) begin
                        tok_valid_q <= 1'b1;
                    end else begin
                        crc_err_q <= 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                    end
                end else if (state_q == RECV) begin
                    cnt_q   <= cnt_q + 4'd1;
                    shift_q <= {tok.bit_in, shift_q[SR_W-1:1]};
                end
            end
        end
    end

    assign tok.busy      = (state_q == RECV);
    assign tok.tok_valid = tok_valid_q;
    assign tok.crc_err   = crc_err_q;
    assign tok.abort     = abort_q;
    assign tok.addr      = addr_q;
    assign tok.endp      = endp_q;
    assign tok.crc_rx    = crc_rx_q;
    assign tok.crc_calc  = crc_calc_q;
    assign tok.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc5_token_checker.sv
// Directed bench for crc5_token_checker: two instances (8-bit and 2-bit
// error counters) share one serial stimulus stream.
module tb_crc5_token_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0;
    logic bit_in = 1'b0;
    logic sop = 1'b0;
    int   total = 0;
    int   bad = 0;

    localparam logic [15:0] W_000 = {5'h17, 11'h000};
    localparam logic [15:0] W_7FF = {5'h1D, 11'h7FF};
    localparam logic [15:0] W_BAD = {5'h17, 11'h001};

    always #5 clk = ~clk;

    crc5_token_checker_if #(.ERR_CNT_W(8)) if8 ();
    crc5_token_checker_if #(.ERR_CNT_W(2)) if2 ();

    assign if8.bit_en = bit_en;
    assign if8.bit_in = bit_in;
    assign if8.sop    = sop;
    assign if2.bit_en = bit_en;
    assign if2.bit_in = bit_in;
    assign if2.sop    = sop;

    crc5_token_checker #(.ERR_CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .tok (if8.slave)
    );

    crc5_token_checker #(.ERR_CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .tok (if2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bit_en = 1'b0;
            sop    = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Sends bits [first, first+n) of word; sop marks bit 0
    task automatic send_bits(input logic [15:0] w, input int first,
                             input int n, input int gap);
        logic [15:0] wv;
        wv = w;
        for (int i = first; i < first + n; i++) begin
            if (gap > 0 && i != first) idle(gap);
            bit_en = 1'b1;
            bit_in = wv[i];
            sop    = (i == 0);
            @(posedge clk);
            #1;
        end
        bit_en = 1'b0;
        sop    = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(if8.busy), 0);
        chk({tag, "_tv"}, 32'(if8.tok_valid), 0);
        chk({tag, "_ce"}, 32'(if8.crc_err), 0);
        chk({tag, "_ab"}, 32'(if8.abort), 0);
        chk({tag, "_addr"}, 32'(if8.addr), 0);
        chk({tag, "_endp"}, 32'(if8.endp), 0);
        chk({tag, "_crx"}, 32'(if8.crc_rx), 0);
        chk({tag, "_ccalc"}, 32'(if8.crc_calc), 0);
        chk({tag, "_cnt8"}, 32'(if8.err_cnt), 0);
        chk({tag, "_cnt2"}, 32'(if2.err_cnt), 0);
    endtask

    initial begin
        int exp2 [5] = '{1, 2, 3, 3, 3};

        @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        // Good all-zero token, continuous bit_en
        send_bits(W_000, 0, 16, 0);
        chk("t0_tv", 32'(if8.tok_valid), 1);
        chk("t0_ce", 32'(if8.crc_err), 0);
        chk("t0_busy", 32'(if8.busy), 0);
        chk("t0_addr", 32'(if8.addr), 0);
        chk("t0_endp", 32'(if8.endp), 0);
        chk("t0_ccalc", 32'(if8.crc_calc), 32'h17);
        chk("t0_crx", 32'(if8.crc_rx), 32'h17);
        chk("t0_cnt", 32'(if8.err_cnt), 0);
        idle(1);
        chk("t0_tv_pulse", 32'(if8.tok_valid), 0);

        // Good all-ones token, one idle cycle between bits
        send_bits(W_7FF, 0, 8, 1);
        chk("t1_busy_mid", 32'(if8.busy), 1);
        send_bits(W_7FF, 8, 8, 1);
        chk("t1_tv", 32'(if8.tok_valid), 1);
        chk("t1_addr", 32'(if8.addr), 32'h7F);
        chk("t1_endp", 32'(if8.endp), 32'hF);
        chk("t1_ccalc", 32'(if8.crc_calc), 32'h1D);

        // Bad CRC
        idle(3);
        send_bits(W_BAD, 0, 16, 0);
        chk("t2_ce", 32'(if8.crc_err), 1);
        chk("t2_tv", 32'(if8.tok_valid), 0);
        chk("t2_ccalc", 32'(if8.crc_calc), 32'h12);
        chk("t2_crx", 32'(if8.crc_rx), 32'h17);
        chk("t2_addr", 32'(if8.addr), 32'h01);
        chk("t2_cnt", 32'(if8.err_cnt), 1);
        idle(1);
        chk("t2_ce_pulse", 32'(if8.crc_err), 0);

        // Abort: 9 bits, then a fresh good token
        send_bits(W_7FF, 0, 9, 0);
        chk("t3_busy", 32'(if8.busy), 1);
        chk("t3_ab_pre", 32'(if8.abort), 0);
        send_bits(W_000, 0, 1, 0);
        chk("t3_ab", 32'(if8.abort), 1);
        chk("t3_busy2", 32'(if8.busy), 1);
        chk("t3_addr_hold", 32'(if8.addr), 32'h01);
        chk("t3_ccalc_hold", 32'(if8.crc_calc), 32'h12);
        send_bits(W_000, 1, 15, 0);
        chk("t3_tv", 32'(if8.tok_valid), 1);
        chk("t3_ab_end", 32'(if8.abort), 0);
        chk("t3_addr", 32'(if8.addr), 0);
        chk("t3_cnt", 32'(if8.err_cnt), 1);
        idle(1);
        chk("t3_tv_pulse", 32'(if8.tok_valid), 0);

        // Saturation: fresh counters, five back-to-back bad tokens
        rst = 1'b1;
        #1;
        chk("t4_rst_cnt", 32'(if2.err_cnt), 0);
        rst = 1'b0;
        idle(1);
        for (int k = 0; k < 5; k++) begin
            send_bits(W_BAD, 0, 16, 0);
            chk($sformatf("t4_ce%0d", k), 32'(if2.crc_err), 1);
            chk($sformatf("t4_cnt2_%0d", k), 32'(if2.err_cnt),
                32'(exp2[k]));
            chk($sformatf("t4_cnt8_%0d", k), 32'(if8.err_cnt), 32'(k + 1));
        end
        idle(1);
        chk("t4_ce_end", 32'(if2.crc_err), 0);

        // Reset in the middle of a token
        send_bits(W_000, 0, 12, 0);
        chk("t5_busy", 32'(if8.busy), 1);
        rst = 1'b1;
        #2;
        chk_zero("t5_rst");
        rst = 1'b0;
        idle(1);
        send_bits(W_000, 0, 16, 0);
        chk("t5_tv", 32'(if8.tok_valid), 1);
        chk("t5_ce", 32'(if8.crc_err), 0);
        chk("t5_ccalc", 32'(if8.crc_calc), 32'h17);
        idle(1);
        chk("t5_tv_pulse", 32'(if8.tok_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
